// File: rtl/ram_lsu_pkg.sv
// Shared definitions for the RAM load/store initiator: size codes, FSM
// state encoding, wait-counter width and small request-decoding helpers.
package ram_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // Wide enough for a RAM hold time of 0..15 extra cycles.
    localparam int WAIT_CNT_W = 4;

    // The reserved size code behaves exactly like a full word.
    function automatic logic sizeIsWord(input logic [1:0] size);
        return size[1];
    endfunction

    // True when the access cannot be served as an aligned access.
    function automatic logic sizeMisaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ram_lsu_lane.sv
// Little-endian lane logic: extracts and extends a byte/half/word from a RAM
// word for loads, and merges store data into a RAM word for read-modify-write.
module ram_lsu_lane
    import ram_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Select the addressed lane, extend it, and build the merged store word.
    always_comb begin
        byteSel = word_i[{lane_i, 3'b000} +: 8];
        halfSel = word_i[{lane_i[1], 4'b0000} +: 16];
        load_o  = word_i;
        merge_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o  = {{24{signed_i & byteSel[7]}}, byteSel};
                merge_o = word_i;
                merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o  = {{16{signed_i & halfSel[15]}}, halfSel};
                merge_o = word_i;
                merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                load_o  = word_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/ram_lsu_initiator.sv
// Load/store initiator for the single-port word RAM. Converts byte-addressed
// byte/half/word requests into word accesses, using read-modify-write for
// sub-word stores. Optional build macro MISALIGN_CHECK_EN rejects misaligned
// or reserved-size requests with resp_err instead of forcing alignment.
module ram_lsu_initiator
    import ram_lsu_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int WAIT_CYCLES = 0
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wre,
    input  logic [31:0]       ram_rdata
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES);

    state_e                  state_q, state_d;
    logic                    reqWrite_q, reqWrite_d;
    logic [1:0]              reqSize_q, reqSize_d;
    logic                    reqSigned_q, reqSigned_d;
    logic [ADDR_W+1:0]       reqAddr_q, reqAddr_d;
    logic [31:0]             reqWdata_q, reqWdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [WAIT_CNT_W-1:0]   waitCnt_q, waitCnt_d;
    logic                    err_q, err_d;

    logic [31:0]             laneWord;
    logic [31:0]             laneLoad;
    logic [31:0]             laneMerge;

    // The lane unit sees live RAM data while reading, then the held word.
    assign laneWord = (state_q == ST_READ) ? ram_rdata : rdata_q;

    ram_lsu_lane u_lane (
        .word_i   (laneWord),
        .size_i   (reqSize_q),
        .signed_i (reqSigned_q),
        .lane_i   (reqAddr_q[1:0]),
        .wdata_i  (reqWdata_q),
        .load_o   (laneLoad),
        .merge_o  (laneMerge)
    );

    assign req_ready  = (state_q == ST_IDLE) && reset;
    assign resp_valid = (state_q == ST_RESP);
    assign ram_wre    = (state_q == ST_WRITE);
    assign ram_addr   = reqAddr_q[ADDR_W+1:2];
    assign ram_wdata  = (state_q == ST_WRITE) ? laneMerge : 32'h0;
    assign resp_rdata = (resp_valid && !reqWrite_q && !err_q) ? rdata_q : 32'h0;
`ifdef MISALIGN_CHECK_EN
    assign resp_err   = resp_valid && err_q;
`else
    assign resp_err   = 1'b0;
`endif

    // Next-state and datapath capture for the request sequencer.
    always_comb begin
        state_d     = state_q;
        reqWrite_d  = reqWrite_q;
        reqSize_d   = reqSize_q;
        reqSigned_d = reqSigned_q;
        reqAddr_d   = reqAddr_q;
        reqWdata_d  = reqWdata_q;
        rdata_d     = rdata_q;
        waitCnt_d   = waitCnt_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    reqWrite_d  = req_write;
                    reqSize_d   = req_size;
                    reqSigned_d = req_signed;
                    reqAddr_d   = req_addr;
                    reqWdata_d  = req_wdata;
                    waitCnt_d   = '0;
                    err_d       = 1'b0;
                    if (req_write && sizeIsWord(req_size)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
`ifdef MISALIGN_CHECK_EN
                    if (sizeMisaligned(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
`else
`endif
                end
            end
            ST_READ: begin
                if (waitCnt_q == WAIT_LAST) begin
                    waitCnt_d = '0;
                    rdata_d   = reqWrite_q ? ram_rdata : laneLoad;
                    state_d   = reqWrite_q ? ST_WRITE : ST_RESP;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and request registers; reset abandons any request in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            reqWrite_q  <= 1'b0;
            reqSize_q   <= 2'b00;
            reqSigned_q <= 1'b0;
            reqAddr_q   <= '0;
            reqWdata_q  <= 32'h0;
            rdata_q     <= 32'h0;
            waitCnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            reqWrite_q  <= reqWrite_d;
            reqSize_q   <= reqSize_d;
            reqSigned_q <= reqSigned_d;
            reqAddr_q   <= reqAddr_d;
            reqWdata_q  <= reqWdata_d;
            rdata_q     <= rdata_d;
            waitCnt_q   <= waitCnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ram_lsu_initiator.sv
// Self-checking bench for ram_lsu_initiator: directed scenarios followed by
// random requests, all compared against a byte-level memory model.
module tb_ram_lsu_initiator;

   localparam int ADDR_W = 7;
   localparam int WAIT   = 2;

   logic              clock;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W+1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic              ram_wre;
   logic [31:0]       ram_rdata;

   logic [31:0] mem    [0:127];
   logic [31:0] refMem [0:127];
   int          wreCnt = 0;
   logic [6:0]  lastWaddr = '0;
   logic [31:0] lastWdata = '0;

   int          nAssert = 0;
   int          nFail   = 0;
   logic [31:0] lastRd;
   logic        lastErr;

   ram_lsu_initiator #(
      .ADDR_W      (ADDR_W),
      .WAIT_CYCLES (WAIT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_wre    (ram_wre),
      .ram_rdata  (ram_rdata)
   );

   // Free-running clock, rising edge every 10 time units.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Word RAM with combinational read, preloaded with memory[i] = i.
   assign ram_rdata = mem[ram_addr];

   initial begin
      for (int i = 0; i < 128; i++) mem[i] <= i;
   end

   always @(posedge clock) begin
      if (ram_wre) begin
         mem[ram_addr] <= ram_wdata;
         wreCnt        <= wreCnt + 1;
         lastWaddr     <= ram_addr;
         lastWdata     <= ram_wdata;
      end
   end

   // Hard stop in case something wedges the whole run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired nAssert=%0d", nAssert);
      $fatal(1, "[TB] watchdog");
   end

   // Whether the request would be rejected when the alignment check is built in.
   function automatic logic modelErr(input logic [1:0] sz, input logic [8:0] addr);
`ifdef MISALIGN_CHECK_EN
      return (sz == 2'd1 && (addr % 2) != 0) || (sz == 2'd2 && (addr % 4) != 0) || (sz == 2'd3);
`else
      return 1'b0;
`endif
   endfunction

   // Value a load returns, computed from the word with shifts and masks.
   function automatic logic [31:0] modelLoad(input logic [1:0] sz, input logic sgn,
                                             input logic [8:0] addr, input logic [31:0] w);
      logic [31:0] v;
      int          off;
      if (sz == 2'd0) begin
         off = addr % 4;
         v = (w >> (8 * off)) & 32'hFF;
         if (sgn && v >= 32'd128) v = v + 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
         off = (addr % 4) / 2;
         v = (w >> (16 * off)) & 32'hFFFF;
         if (sgn && v >= 32'd32768) v = v + 32'hFFFF0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   // Word that results from applying a store to the old word.
   function automatic logic [31:0] modelMerge(input logic [1:0] sz, input logic [8:0] addr,
                                              input logic [31:0] wd, input logic [31:0] w);
      logic [31:0] mask;
      int          off;
      if (sz == 2'd0) begin
         off  = 8 * (addr % 4);
         mask = 32'hFF << off;
         return (w & ~mask) | ((wd & 32'hFF) << off);
      end else if (sz == 2'd1) begin
         off  = 16 * ((addr % 4) / 2);
         mask = 32'hFFFF << off;
         return (w & ~mask) | ((wd & 32'hFFFF) << off);
      end
      return wd;
   endfunction

   // One comparison point: counts it, reports and counts it if it differs.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Run one request through the handshake and check the whole response.
   task automatic applyStimulus(input string name, input logic wr, input logic [1:0] sz,
                                input logic sgn, input logic [8:0] addr, input logic [31:0] wd);
      logic        expErr;
      logic [31:0] expRd;
      logic [31:0] expWord;
      int          expLat;
      int          expWre;
      int          idx;
      int          wre0;
      int          lat;
      logic        seen;
      idx     = int'(addr) / 4;
      expErr  = modelErr(sz, addr);
      expRd   = 32'h0;
      expWord = refMem[idx];
      expWre  = 0;
      if (expErr) begin
         expLat = 1;
      end else if (!wr) begin
         expRd  = modelLoad(sz, sgn, addr, refMem[idx]);
         expLat = 2 + WAIT;
      end else begin
         expWord = modelMerge(sz, addr, wd, refMem[idx]);
         expWre  = 1;
         expLat  = sz[1] ? 2 : 3 + WAIT;
      end
      req_write  = wr;
      req_size   = sz;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wd;
      req_valid  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (req_ready) begin
            seen = 1'b1;
            break;
         end
         @(posedge clock); #1;
      end
      checkOutput({name, " handshake"}, seen, 1);
      wre0 = wreCnt;
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat  = 1;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (resp_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clock); #1;
         lat++;
      end
      checkOutput({name, " resp_seen"}, seen, 1);
      checkOutput({name, " latency"}, lat, expLat);
      checkOutput({name, " rdata"}, resp_rdata, expRd);
      checkOutput({name, " err"}, resp_err, expErr);
      checkOutput({name, " wre_count"}, wreCnt - wre0, expWre);
      lastRd  = resp_rdata;
      lastErr = resp_err;
      if (expWre == 1) begin
         checkOutput({name, " waddr"}, lastWaddr, idx);
         checkOutput({name, " wdata"}, lastWdata, expWord);
         refMem[idx] = expWord;
      end
      @(posedge clock); #1;
      checkOutput({name, " pulse_end"}, resp_valid, 0);
      checkOutput({name, " ready_again"}, req_ready, 1);
   endtask

   // Directed scenarios, then a random sweep, then the summary.
   initial begin
      int          lat;
      int          wre0;
      logic        seen;
      logic [1:0]  rsz;
      logic        rwr;
      for (int i = 0; i < 128; i++) refMem[i] = i;
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = 32'h0;
      lastRd     = 32'h0;
      lastErr    = 1'b0;

      // Reset state, with a request offered that must be ignored.
      repeat (2) @(posedge clock);
      #1;
      req_valid = 1'b1;
      @(posedge clock); #1;
      checkOutput("rst req_ready", req_ready, 0);
      checkOutput("rst resp_valid", resp_valid, 0);
      checkOutput("rst resp_err", resp_err, 0);
      checkOutput("rst ram_wre", ram_wre, 0);
      checkOutput("rst resp_rdata", resp_rdata, 0);
      checkOutput("rst ram_addr", ram_addr, 0);
      checkOutput("rst ram_wdata", ram_wdata, 0);
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock); #1;

      // Word load of preloaded data, then word store and read back.
      applyStimulus("ld_w_014", 1'b0, 2'd2, 1'b0, 9'h014, 32'h0);
      checkOutput("ld_w_014 const", lastRd, 32'h00000005);
      applyStimulus("st_w_020", 1'b1, 2'd2, 1'b0, 9'h020, 32'hDEADBEEF);
      applyStimulus("ld_w_020", 1'b0, 2'd2, 1'b0, 9'h020, 32'h0);
      checkOutput("ld_w_020 const", lastRd, 32'hDEADBEEF);

      // Byte store through read-modify-write and lane extraction.
      applyStimulus("st_b_021", 1'b1, 2'd0, 1'b0, 9'h021, 32'h00000080);
      applyStimulus("ld_w_020b", 1'b0, 2'd2, 1'b0, 9'h020, 32'h0);
      checkOutput("ld_w_020b const", lastRd, 32'hDEAD80EF);
      applyStimulus("ld_sb_021", 1'b0, 2'd0, 1'b1, 9'h021, 32'h0);
      checkOutput("ld_sb_021 const", lastRd, 32'hFFFFFF80);
      applyStimulus("ld_ub_021", 1'b0, 2'd0, 1'b0, 9'h021, 32'h0);
      checkOutput("ld_ub_021 const", lastRd, 32'h00000080);
      applyStimulus("ld_sh_022", 1'b0, 2'd1, 1'b1, 9'h022, 32'h0);
      checkOutput("ld_sh_022 const", lastRd, 32'hFFFFDEAD);

      // Top word of the RAM is an ordinary location.
      applyStimulus("st_w_1fc", 1'b1, 2'd2, 1'b0, 9'h1FC, 32'h12345678);
      applyStimulus("ld_w_1fc", 1'b0, 2'd2, 1'b0, 9'h1FC, 32'h0);
      checkOutput("ld_w_1fc const", lastRd, 32'h12345678);

      // req_valid held high: busy window, then re-acceptance after the pulse.
      req_write  = 1'b0;
      req_size   = 2'd2;
      req_signed = 1'b0;
      req_addr   = 9'h014;
      req_valid  = 1'b1;
      checkOutput("hold ready_start", req_ready, 1);
      @(posedge clock); #1;
      lat  = 1;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (resp_valid) begin
            seen = 1'b1;
            break;
         end
         checkOutput("hold busy_ready", req_ready, 0);
         @(posedge clock); #1;
         lat++;
      end
      checkOutput("hold resp1_seen", seen, 1);
      checkOutput("hold resp1_latency", lat, 2 + WAIT);
      checkOutput("hold resp1_rdata", resp_rdata, 32'h00000005);
      checkOutput("hold resp_ready", req_ready, 0);
      @(posedge clock); #1;
      checkOutput("hold idle_ready", req_ready, 1);
      checkOutput("hold idle_resp", resp_valid, 0);
      @(posedge clock); #1;
      checkOutput("hold accepted", req_ready, 0);
      req_valid = 1'b0;
      lat  = 1;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (resp_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clock); #1;
         lat++;
      end
      checkOutput("hold resp2_seen", seen, 1);
      checkOutput("hold resp2_latency", lat, 2 + WAIT);
      checkOutput("hold resp2_rdata", resp_rdata, 32'h00000005);
      @(posedge clock); #1;

      // Reset while the byte store is writing: write and response must vanish.
      wre0       = wreCnt;
      req_write  = 1'b1;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = 9'h021;
      req_wdata  = 32'h00000011;
      req_valid  = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (ram_wre) begin
            seen = 1'b1;
            break;
         end
         checkOutput("abort no_resp_before", resp_valid, 0);
         @(posedge clock); #1;
      end
      checkOutput("abort write_seen", seen, 1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("abort wre_drop", ram_wre, 0);
      checkOutput("abort resp_low", resp_valid, 0);
      checkOutput("abort ready_low", req_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         checkOutput("abort resp_in_reset", resp_valid, 0);
         checkOutput("abort wre_in_reset", ram_wre, 0);
      end
      reset = 1'b1;
      checkOutput("abort wre_count", wreCnt - wre0, 0);
      checkOutput("abort word8_model", mem[8], refMem[8]);
      checkOutput("abort word8_const", mem[8], 32'hDEAD80EF);
      @(posedge clock); #1;
      checkOutput("abort no_late_resp", resp_valid, 0);
      applyStimulus("ld_w_020c", 1'b0, 2'd2, 1'b0, 9'h020, 32'h0);
      checkOutput("ld_w_020c const", lastRd, 32'hDEAD80EF);

      // Misaligned half load: rejected with the check, forced-aligned without.
      applyStimulus("ld_h_021", 1'b0, 2'd1, 1'b0, 9'h021, 32'h0);
`ifdef MISALIGN_CHECK_EN
      checkOutput("ld_h_021 err_const", lastErr, 1);
      checkOutput("ld_h_021 rdata_const", lastRd, 32'h0);
`else
      checkOutput("ld_h_021 err_const", lastErr, 0);
      checkOutput("ld_h_021 rdata_const", lastRd, 32'h000080EF);
`endif

      // Random mix of loads and stores over the whole address range.
      for (int n = 0; n < 80; n++) begin
         rwr = 1'($urandom_range(0, 1));
         rsz = 2'($urandom_range(0, 3));
         applyStimulus($sformatf("rnd%0d", n), rwr, rsz, 1'($urandom_range(0, 1)),
                       9'($urandom_range(0, 511)), $urandom);
      end

      // Final sweep of the RAM against the model.
      for (int i = 0; i < 128; i += 9) begin
         checkOutput($sformatf("final word%0d", i), mem[i], refMem[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule

// File: doc/ram_lsu_initiator.md
Name: ram_lsu_initiator

Overview:
Load/store initiator that drives the single-port 128x32 word RAM on behalf of the core datapath. Accepts byte-addressed byte/half/word requests over a valid/ready handshake and converts them into word RAM accesses. Sub-word stores use read-modify-write. Loads are lane-extracted and sign- or zero-extended, and each request returns a one-cycle response pulse.

Parameters:
ADDR_W, 7, word-address width of the RAM port (byte address is ADDR_W+2 bits)
WAIT_CYCLES, 0, extra cycles the RAM address is held before ram_rdata is sampled (0..15)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_write  input  1  1 store, 0 load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  input  1  loads: 1 sign-extend, 0 zero-extend
req_addr  input  ADDR_W+2  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores
resp_err  output  1  request rejected (feature only, else 0)
ram_addr  output  ADDR_W  word address to RAM
ram_wdata  output  32  word write data to RAM
ram_wre  output  1  RAM write enable
ram_rdata  input  32  RAM combinational read data

Behaviour:
- Reset (reset low, async):
  - state IDLE; req_ready, resp_valid, resp_err, ram_wre = 0.
  - resp_rdata, ram_addr, ram_wdata = 0; wait counter = 0.
  - ram_wre must be 0 throughout reset so it cannot disturb the RAM preload.
- Lanes are little-endian: byte n = bits [8n+7:8n].
  - Byte lane = addr[1:0]; half lane = addr[1]; word ignores addr[1:0].
- States: IDLE, READ, WRITE, RESP. req_ready = (state==IDLE) && reset high.
- IDLE:
  - Handshake fires when req_valid && req_ready.
  - On handshake, latch all req_* fields.
  - Next state: word store -> WRITE; load or sub-word store -> READ.
- READ:
  - ram_addr = latched addr[ADDR_W+1:2]; ram_wre = 0.
  - Counter runs 0..WAIT_CYCLES. At WAIT_CYCLES, sample ram_rdata.
  - Then: load -> RESP; sub-word store -> WRITE.
- WRITE:
  - ram_wre = 1 for exactly one cycle; ram_addr = latched word address.
  - Word store: ram_wdata = latched wdata.
  - Sub-word store: ram_wdata = sampled word with the selected lane replaced by wdata[7:0] or wdata[15:0].
  - Next state: RESP.
- RESP:
  - resp_valid = 1 for one cycle; there is no response backpressure.
  - Load: resp_rdata = extended lane. Store: resp_rdata = 0.
  - Next state: IDLE. req_ready stays low in RESP.
- Latency from the handshake edge to resp_valid high:
  - load: 2+WAIT_CYCLES cycles
  - word store: 2 cycles
  - sub-word store: 3+WAIT_CYCLES cycles
- req_size 11 is treated as word.
- req_valid asserted while busy is ignored (not accepted). Requesters hold it until the handshake.
- Reset mid-operation aborts immediately: no write issued (including reset during WRITE, where ram_wre drops asynchronously), no response, request lost.
- Address wrap: there is no wrap logic; the top word (127) is accessed normally.

Optional Feature:
MISALIGN_CHECK_EN:
- Defined:
  - Half with addr[0]=1, word with addr[1:0]!=0, or req_size 11 goes IDLE->RESP directly with no RAM access.
  - In that RESP: resp_err = 1, resp_rdata = 0; latency 1 cycle.
- Undefined: offending address bits are ignored (forced alignment) and resp_err is tied 0.

Decomposition:
- Package ram_lsu_pkg holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - FSM state encoding
  - WAIT counter width constant
- Sub-module ram_lsu_lane (combinational) holds lane extract + extension and store merge. It is shared by the READ sample path and the WRITE merge path.

Test Plan:
- Word load, addr 0x014, RAM preloaded with memory[i]=i -> resp_rdata 0x00000005 exactly 2 cycles after handshake; ram_wre never 1.
- Word store 0xDEADBEEF to addr 0x020:
  - ram_wre high one cycle with ram_addr=8, ram_wdata=0xDEADBEEF.
  - A following word load of 0x020 -> 0xDEADBEEF.
- Byte store 0x80 to 0x021, then:
  - word load 0x020 -> 0xDEAD80EF
  - signed byte load 0x021 -> 0xFFFFFF80; unsigned -> 0x00000080
  - signed half load 0x022 -> 0xFFFFDEAD
- WAIT_CYCLES=2, req_valid held high continuously:
  - load latency 4 cycles; req_ready low through READ/RESP.
  - Second request accepted only on the cycle after resp_valid.
- Reset asserted during WRITE of a byte store to 0x021 -> ram_wre drops immediately, no resp_valid; word 8 unchanged after a non-preload reset sequence check.
- With MISALIGN_CHECK_EN, half load at 0x021 -> resp_valid and resp_err 1 cycle after handshake, resp_rdata 0, ram_wre 0.
  - Without the macro -> same request returns the half at 0x020.
